// File: rtl/video_pattern_gen_if.sv
// Signal bundle between the video pattern generator and its sink:
// pattern controls flow into the generator, timing and pixel data flow out.
interface video_pattern_gen_if #(
   parameter int COLOR_W = 8
);
   logic [1:0]         mode;
   logic [2:0]         chan_en;
   logic               scandouble;
   logic               ce_pix;
   logic               HBlank;
   logic               HSync;
   logic               VBlank;
   logic               VSync;
   logic [COLOR_W-1:0] r;
   logic [COLOR_W-1:0] g;
   logic [COLOR_W-1:0] b;
   logic [15:0]        frame_cnt;

   modport master (
      input  mode, chan_en, scandouble,
      output ce_pix, HBlank, HSync, VBlank, VSync, r, g, b, frame_cnt
   );

   modport slave (
      output mode, chan_en, scandouble,
      input  ce_pix, HBlank, HSync, VBlank, VSync, r, g, b, frame_cnt
   );
endinterface

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator: noise, colour bars, grid and gradient,
// with optional scan doubling (twice the pixel rate, every line repeated).
module video_pattern_gen #(
   parameter int H_ACTIVE = 320,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 32,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 240,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 15,
   parameter int CE_DIV   = 4,
   parameter int COLOR_W  = 8
) (
   input  logic                clk,
   input  logic                reset,
   video_pattern_gen_if.master vid
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(2 * V_TOTAL + 1);
   localparam int DW      = $clog2(CE_DIV);
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST_1X  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST_2X  = VW'(2 * V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [DW-1:0] DIV_LAST_1X = DW'(CE_DIV - 1);
   localparam logic [DW-1:0] DIV_LAST_2X = DW'(CE_DIV / 2 - 1);
   localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);
   localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting towards bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [COLOR_W-1:0] expand(input logic bit_in);
      expand = {COLOR_W{bit_in}};
   endfunction

   logic [DW-1:0]      div_p0;
   logic [DW-1:0]      div_last;
   logic               sd_p0;
   logic               tick;
   logic [HW-1:0]      hcnt_p0;
   logic [VW-1:0]      vcnt_p0;
   logic [VW-1:0]      v_last;
   logic [VW-1:0]      y;
   logic               h_wrap;
   logic               v_wrap;
   logic [BW-1:0]      bar_cnt_p0;
   logic [2:0]         bar_idx_p0;
   logic [15:0]        lfsr_p0;
   logic [1:0]         mode_p0;
   logic [1:0]         mode_eff;
   logic               hblank_d, hsync_d, vblank_d, vsync_d, grid_on;
   logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
   logic               ce_p1, hblank_p1, hsync_p1, vblank_p1, vsync_p1;
   logic [COLOR_W-1:0] r_p1, g_p1, b_p1;
   logic [15:0]        frame_cnt_p1;

   // Stage p0: pixel-enable divider; a scandouble change restarts it from zero.
   assign div_last = vid.scandouble ? DIV_LAST_2X : DIV_LAST_1X;
   assign tick     = (div_p0 == div_last) && (vid.scandouble == sd_p0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_p0 <= '0;
         sd_p0  <= 1'b0;
         ce_p1  <= 1'b0;
      end else begin
         sd_p0 <= vid.scandouble;
         ce_p1 <= tick;
         if (tick || (vid.scandouble != sd_p0))
            div_p0 <= '0;
         else
            div_p0 <= div_p0 + 1'b1;
      end
   end

   assign v_last = vid.scandouble ? V_LAST_2X : V_LAST_1X;
   assign h_wrap = (hcnt_p0 == H_LAST);
   assign v_wrap = (vcnt_p0 >= v_last);
   assign y      = vid.scandouble ? {1'b0, vcnt_p0[VW-1:1]} : vcnt_p0;
   assign mode_eff = ((hcnt_p0 == '0) && (vcnt_p0 == '0)) ? vid.mode : mode_p0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt_p0      <= '0;
         vcnt_p0      <= '0;
         bar_cnt_p0   <= '0;
         bar_idx_p0   <= '0;
         lfsr_p0      <= LFSR_SEED;
         mode_p0      <= 2'd0;
         frame_cnt_p1 <= 16'd0;
      end else if (tick) begin
         lfsr_p0 <= lfsr_step(lfsr_p0);
         mode_p0 <= mode_eff;
         if (h_wrap) begin
            hcnt_p0    <= '0;
            bar_cnt_p0 <= '0;
            bar_idx_p0 <= '0;
            if (v_wrap) begin
               vcnt_p0      <= '0;
               frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
            end else begin
               vcnt_p0 <= vcnt_p0 + 1'b1;
            end
         end else begin
            hcnt_p0 <= hcnt_p0 + 1'b1;
            if (bar_cnt_p0 == BAR_LAST) begin
               bar_cnt_p0 <= '0;
               bar_idx_p0 <= bar_idx_p0 + 3'd1;
            end else begin
               bar_cnt_p0 <= bar_cnt_p0 + 1'b1;
            end
         end
      end
   end

   assign hblank_d = (hcnt_p0 >= H_ACT);
   assign hsync_d  = (hcnt_p0 >= HS_BEG) && (hcnt_p0 < HS_END);
   assign vblank_d = (y >= V_ACT);
   assign vsync_d  = (y >= VS_BEG) && (y < VS_END);
   assign grid_on  = (hcnt_p0[3:0] == 4'd0) || (y[3:0] == 4'd0) ||
                     (hcnt_p0 == H_ACT_LAST) || (y == V_ACT_LAST);

   always_comb begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      case (mode_eff)
         2'd0: begin
            pix_r = lfsr_p0[15 -: COLOR_W];
            pix_g = lfsr_p0[15 -: COLOR_W];
            pix_b = lfsr_p0[15 -: COLOR_W];
         end
         2'd1: begin
            pix_r = expand(~bar_idx_p0[1]);
            pix_g = expand(~bar_idx_p0[2]);
            pix_b = expand(~bar_idx_p0[0]);
         end
         2'd2: begin
            pix_r = expand(grid_on);
            pix_g = expand(grid_on);
            pix_b = expand(grid_on);
         end
         default: begin
            pix_r = COLOR_W'(hcnt_p0);
            pix_g = COLOR_W'(hcnt_p0);
            pix_b = COLOR_W'(hcnt_p0);
         end
      endcase
      if (!vid.chan_en[2]) pix_r = '0;
      if (!vid.chan_en[1]) pix_g = '0;
      if (!vid.chan_en[0]) pix_b = '0;
      if (hblank_d || vblank_d) begin
         pix_r = '0;
         pix_g = '0;
         pix_b = '0;
      end
   end

   // Stage p1: timing and pixel data captured together for the same (hcnt, y).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hblank_p1 <= 1'b0;
         hsync_p1  <= 1'b0;
         vblank_p1 <= 1'b0;
         vsync_p1  <= 1'b0;
         r_p1      <= '0;
         g_p1      <= '0;
         b_p1      <= '0;
      end else if (tick) begin
         hblank_p1 <= hblank_d;
         hsync_p1  <= hsync_d;
         vblank_p1 <= vblank_d;
         vsync_p1  <= vsync_d;
         r_p1      <= pix_r;
         g_p1      <= pix_g;
         b_p1      <= pix_b;
      end
   end

   assign vid.ce_pix    = ce_p1;
   assign vid.HBlank    = hblank_p1;
   assign vid.HSync     = hsync_p1;
   assign vid.VBlank    = vblank_p1;
   assign vid.VSync     = vsync_p1;
   assign vid.r         = r_p1;
   assign vid.g         = g_p1;
   assign vid.b         = b_p1;
   assign vid.frame_cnt = frame_cnt_p1;
endmodule
